operand_normalizer: RTL

- Upstream stage of the 16-bit operand shift register in the approximate-multiplier datapath.
- Takes a 16-bit operand and left-shifts it until its leading one reaches the MSB, or until MAX_SHIFT shifts have been done.
- Returns the top OUT_WIDTH bits as a mantissa, plus the shift count the downstream de-normalizer needs to rescale the product.
- Runs a start/done handshake, one shift per cycle.

---
 rtl/operand_normalizer.sv | 94 +++++++++
 1 files changed

// File: rtl/operand_normalizer.sv
// Iterative left-shift normalizer: shifts an operand until its leading one
// reaches the MSB (or MAX_SHIFT is hit) and reports mantissa + shift count.
module operand_normalizer #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 8,
    parameter int MAX_SHIFT = 8,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_in,
    output logic                 busy,
    output logic                 done,
    output logic [OUT_WIDTH-1:0] mantissa,
    output logic [CNT_W-1:0]     shift_count,
    output logic                 zero
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIFT);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] mant_q, mant_d;
    logic [CNT_W-1:0]     sc_q, sc_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic                 term;

    // Stop once normalized or at the shift limit; a zero operand runs to the limit.
    assign term = opnd_q[WIDTH-1] || (cnt_q == MAX_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            cnt_q   <= '0;
            mant_q  <= '0;
            sc_q    <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            mant_q  <= mant_d;
            sc_q    <= sc_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        mant_d  = mant_q;
        sc_d    = sc_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (term) begin
                    mant_d  = opnd_q[WIDTH-1:WIDTH-OUT_WIDTH];
                    sc_d    = cnt_q;
                    zero_d  = (opnd_q == '0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    opnd_d = {opnd_q[WIDTH-2:0], 1'b0};
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == SHIFT);
    assign done        = done_q;
    assign mantissa    = mant_q;
    assign shift_count = sc_q;
    assign zero        = zero_q;

endmodule
